// File: rtl/chan_arbiter.sv
// Round-robin block merger: grants one channel processor at a time, sizes the transfer
// from its header word and streams the whole block onto a single 16-bit output.
module chan_arbiter #(
  parameter int NCH  = 16,
  parameter int PTRW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  output logic [NCH-1:0]    ack,
  input  logic [16*NCH-1:0] chdata,
  input  logic              afull,
  output logic [15:0]       dout,
  output logic              dout_we,
  output logic              dout_last,
  output logic [PTRW-1:0]   grant_num,
  output logic              busy,
  output logic [15:0]       err_cnt,
  output logic [1:0]        o_dbg_state
);

  // Handshake: ack[c] high in cycle t consumes the word currently on chdata[c]; the channel
  // presents its next word in t+1. The consumed word appears on dout with dout_we in t+1.
  typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_XFER, ST_DRAIN} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PTRW-1:0] r_rr_ptr;
  logic [PTRW-1:0] r_grant;
  logic [8:0]      r_remain;
  logic [15:0]     r_dout;
  logic            r_dout_we;
  logic            r_dout_last;
  logic            r_busy;
  logic [15:0]     r_err_cnt;

  logic [NCH-1:0]  w_hi;
  logic [PTRW-1:0] w_sel_hi;
  logic [PTRW-1:0] w_sel_lo;
  logic [PTRW-1:0] w_sel;
  logic [15:0]     w_word;
  logic            w_ack_en;
  logic            w_xfer_ack;

  // Channels above the pointer win first; otherwise the lowest requester wraps around,
  // so the last granted channel ends up with the lowest priority.
  always_comb begin
    w_hi     = '0;
    w_sel_hi = '0;
    w_sel_lo = '0;
    for (int c = 0; c < NCH; c++) begin
      w_hi[c] = req[c] && (c > int'(r_rr_ptr));
    end
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_hi[c]) w_sel_hi = PTRW'(c);
      if (req[c])  w_sel_lo = PTRW'(c);
    end
    w_sel = (|w_hi) ? w_sel_hi : w_sel_lo;
  end

  always_comb begin
    w_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_grant == PTRW'(c)) w_word = chdata[16*c +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (|req) w_next = ST_HEAD;
      ST_HEAD:  w_next = w_word[15] ? ST_XFER : ST_IDLE;
      ST_XFER:  if (w_ack_en && (r_remain == 9'd1)) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // A header without bit 15 is dropped with a single ack so the channel can resync.
  always_comb begin
    w_ack_en = 1'b0;
    case (r_state)
      ST_HEAD: w_ack_en = !w_word[15];
      ST_XFER: w_ack_en = !afull && (r_remain != 9'd0);
      default: w_ack_en = 1'b0;
    endcase
    w_xfer_ack = w_ack_en && (r_state == ST_XFER);
    ack = '0;
    for (int c = 0; c < NCH; c++) begin
      ack[c] = w_ack_en && (r_grant == PTRW'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_remain    <= '0;
      r_dout      <= '0;
      r_dout_we   <= 1'b0;
      r_dout_last <= 1'b0;
      r_busy      <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_dout_we   <= w_xfer_ack;
      r_dout_last <= w_xfer_ack && (r_remain == 9'd1);
      if (w_xfer_ack) r_dout <= w_word;
      case (r_state)
        ST_IDLE: begin
          if (|req) r_grant <= w_sel;
        end
        ST_HEAD: begin
          if (!w_word[15]) begin
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
          end else begin
            // Master-trigger blocks carry an extra trigger word after the header.
            r_remain <= {1'b0, w_word[7:0]} + (w_word[14] ? 9'd2 : 9'd1);
            r_busy   <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_ack_en) r_remain <= r_remain - 9'd1;
        end
        ST_DRAIN: begin
          r_busy   <= 1'b0;
          r_rr_ptr <= r_grant;
        end
        default: ;
      endcase
    end
  end

  assign dout        = r_dout;
  assign dout_we     = r_dout_we;
  assign dout_last   = r_dout_last;
  assign grant_num   = r_grant;
  assign busy        = r_busy;
  assign err_cnt     = r_err_cnt;
  assign o_dbg_state = r_state;

endmodule
